// File: rtl/alu_share_pkg.sv
// alu_share_pkg: shared definitions for the ALU-sharing arbiter.
//   - ALU select codes understood by the shared N_Bit_ALU
//   - FSM state encoding
//   - sel_legal(): true for the four supported select codes
package alu_share_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic sel_legal(input logic [3:0] sel);
    return (sel == ALU_ADD) || (sel == ALU_SUB) ||
           (sel == ALU_AND) || (sel == ALU_OR);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant logic with its priority register.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-low reset (prio -> 0)
//   valid    in   [1:0] request valids
//   advance  in   a grant was consumed this cycle; flip priority away from it
//   grant    out  [1:0] one-hot grant (all-zero when nothing is valid)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  // r_prio names the requester that wins when both are valid
  logic r_prio;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // After serving requester g the other one gets priority: prio = ~g.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prio <= 1'b0;
    end else if (advance) begin
      r_prio <= grant[0];
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one N-bit ALU between two requesters.
// Requests are granted round-robin, operands are registered and driven to
// the ALU for one cycle, and the captured result is returned with the
// requester id on a valid/ready response channel.
//
// Optional feature macro: ALU_SHARE_ARBITER_PERF_EN adds perf_grant0,
// perf_grant1 and perf_stall saturating counters.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   req_valid/req_ready [1:0] request handshake per requester
//   req_a, req_b [2N]         operands, requester i at [i*N +: N]
//   req_sel [8]               select, requester i at [i*4 +: 4]
//   rsp_*                     response channel (valid/ready + payload)
//   alu_a, alu_b, alu_sel     drive to the shared ALU
//   alu_result, alu_zero, alu_cout_add, alu_cout_sub  ALU outputs
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrate; req_ready high for the granted requester
// EXEC  | ALU driven from operand registers; capture at end of cycle
// RESP  | rsp_valid high; hold until rsp_ready
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*N-1:0] req_a,
  input  logic [2*N-1:0] req_b,
  input  logic [7:0]     req_sel,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [N-1:0]   rsp_result,
  output logic           rsp_zero,
  output logic           rsp_carry,
  output logic           rsp_err,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic [3:0]     alu_sel,
  input  logic [N-1:0]   alu_result,
  input  logic           alu_zero,
  input  logic           alu_cout_add,
  input  logic           alu_cout_sub
`ifdef ALU_SHARE_ARBITER_PERF_EN
  ,
  output logic [15:0]    perf_grant0,
  output logic [15:0]    perf_grant1,
  output logic [15:0]    perf_stall
`endif
);

  state_t       r_state;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [3:0]   r_sel;
  logic         r_id;
  logic         r_rsp_valid;
  logic         r_rsp_id;
  logic [N-1:0] r_rsp_result;
  logic         r_rsp_zero;
  logic         r_rsp_carry;
  logic         r_rsp_err;

  logic [1:0]   w_grant;
  logic         w_hs;
  logic         w_gid;
  logic [N-1:0] w_a;
  logic [N-1:0] w_b;
  logic [3:0]   w_sel;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (req_valid),
    .advance (w_hs),
    .grant   (w_grant)
  );

  // Ready is gated by rst so nothing can be accepted while reset is held.
  assign req_ready = (rst && (r_state == IDLE)) ? w_grant : 2'b00;
  assign w_hs      = |(req_valid & req_ready);
  assign w_gid     = w_grant[1];
  assign w_a       = w_gid ? req_a[2*N-1:N] : req_a[N-1:0];
  assign w_b       = w_gid ? req_b[2*N-1:N] : req_b[N-1:0];
  assign w_sel     = w_gid ? req_sel[7:4]   : req_sel[3:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_sel        <= ALU_ADD;
      r_id         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_carry  <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_a     <= w_a;
            r_b     <= w_b;
            r_sel   <= w_sel;
            r_id    <= w_gid;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_id;
          if (sel_legal(r_sel)) begin
            r_rsp_result <= alu_result;
            r_rsp_zero   <= alu_zero;
            r_rsp_carry  <= (r_sel == ALU_ADD) ? alu_cout_add :
                            (r_sel == ALU_SUB) ? alu_cout_sub : 1'b0;
            r_rsp_err    <= 1'b0;
          end else begin
            // Illegal select: the ALU output is meaningless, report an error.
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_carry  <= 1'b0;
            r_rsp_err    <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_sel    = r_sel;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_err    = r_rsp_err;

`ifdef ALU_SHARE_ARBITER_PERF_EN
  logic [15:0] r_perf_grant0;
  logic [15:0] r_perf_grant1;
  logic [15:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_grant0 <= '0;
      r_perf_grant1 <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_hs && !w_gid && (r_perf_grant0 != 16'hFFFF))
        r_perf_grant0 <= r_perf_grant0 + 16'd1;
      if (w_hs && w_gid && (r_perf_grant1 != 16'hFFFF))
        r_perf_grant1 <= r_perf_grant1 + 16'd1;
      if ((r_state == RESP) && !rsp_ready && (r_perf_stall != 16'hFFFF))
        r_perf_stall <= r_perf_stall + 16'd1;
    end
  end

  assign perf_grant0 = r_perf_grant0;
  assign perf_grant1 = r_perf_grant1;
  assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter and sequencer for the single shared 32-bit ALU (N_Bit_ALU). It accepts operation requests from two clients over valid/ready, grants the ALU round-robin, and drives the operands and select code from registers. It captures the ALU result, zero flag and the relevant carry, then returns them with a requester ID over a valid/ready response channel. It sits between the execute-stage clients (e.g. the main datapath and an address/branch helper) and the one ALU instance.

## Interface
- N, 32, operand/result width.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; at most one bit high.
- req_a  in  2*N  operand A; bits [i*N +: N] belong to requester i.
- req_b  in  2*N  operand B, same packing.
- req_sel  in  8  ALU select; bits [i*4 +: 4] belong to requester i.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_id  out  1  requester index of the response.
- rsp_result  out  N  captured ALU result.
- rsp_zero  out  1  captured zero flag.
- rsp_carry  out  1  carry for ADD/SUB; 0 otherwise.
- rsp_err  out  1  illegal select code.
- alu_a, alu_b  out  N  ALU operands.
- alu_sel  out  4  ALU select.
- alu_result  in  N  ALU output.
- alu_zero  in  1  ALU zero flag.
- alu_cout_add, alu_cout_sub  in  1  ALU carries.

## Operation
- Legal selects: ADD 4'b0010, SUB 4'b0110, AND 4'b0000, OR 4'b0001. Any other code is illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE: `req_ready[g]` is high combinationally for the granted requester `g`.
  - Only one request valid: grant it.
  - Both valid: grant the requester named by `prio`.
  - A handshake (`valid & ready`) latches a, b, sel and id into the operand registers, sets `prio = ~g`, and moves to EXEC.
- EXEC: `alu_a`, `alu_b` and `alu_sel` are driven from the operand registers. At the end of the cycle the block captures into the response registers and moves to RESP:
  - `rsp_result = alu_result`, `rsp_zero = alu_zero`.
  - `rsp_carry` = `alu_cout_add` for ADD, `alu_cout_sub` for SUB, 0 otherwise.
  - `rsp_err = 0`.
- Illegal select: EXEC still lasts one cycle, but the capture is result=0, zero=0, carry=0, err=1.
- RESP: `rsp_valid` is high. The response fields are stable until `rsp_ready`. On `rsp_ready`, go to IDLE.
- `req_ready` is 0 in EXEC and RESP.
- Requesters hold valid and payload stable until ready. An unaccepted request may not change.
- The ALU operand registers keep their last value in IDLE/RESP. They do not toggle without a grant.

## Timing
- Reset, applied while `rst = 0` at a clock edge:
  - state = IDLE, `prio` = 0.
  - `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_zero`, `rsp_carry`, `rsp_err` = 0.
  - `alu_a`, `alu_b` = 0; `alu_sel` = 4'b0010.
  - `req_ready` = 0 while `rst` is low.
- Reset mid-operation: any EXEC/RESP transaction is dropped without a response, and the FSM restarts in IDLE on the first cycle after release.
- Latency: accept at edge t; EXEC during cycle t..t+1; `rsp_valid` high from edge t+1.
- Zero-wait throughput: one op per 3 cycles (IDLE, EXEC, RESP with `rsp_ready` high).
- Back-pressure: RESP holds indefinitely while `rsp_ready = 0`. No new request is accepted.
- A new request asserted during RESP is seen in the IDLE cycle that follows. Arbitration is evaluated in IDLE only.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…
- Arithmetic: N-bit modulo. Carry is taken from the ALU; no extension.

## Configuration
- `ALU_SHARE_ARBITER_PERF_EN`
  - Defined: adds outputs `perf_grant0`, `perf_grant1` (16 bits each) and `perf_stall` (16 bits).
    - `perf_grant0`/`perf_grant1`: saturating grant counters per requester.
    - `perf_stall`: counts cycles in RESP with `rsp_ready = 0`, saturating at 16'hFFFF.
    - All cleared by reset.
  - Undefined: these ports and counters do not exist. Functional behaviour is identical.

## Structure
- Package `alu_share_pkg`:
  - select constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR;
  - state encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2;
  - function `sel_legal(sel)`.
- One sub-module, `rr_arb2`, holds the two-input round-robin grant logic and the `prio` register. It takes `valid[1:0]` and `advance`, and outputs a one-hot `grant[1:0]`.
- The FSM, operand registers, response registers and optional counters stay in the top level.

## Test plan
- Reset release, req0 ADD a=5, b=7 -> `req_ready[0]` high in the first IDLE cycle; two edges later `rsp_valid=1`, id=0, result=12, zero=0, carry=0, err=0.
- req1 SUB a=3, b=3 -> result=0, zero=1, carry=1 (`alu_cout_sub`). Then req1 SUB a=0, b=1 -> result=32'hFFFFFFFF, carry=0.
- Both requesters held valid for 6 ops with `rsp_ready=1` -> grant order 0,1,0,1,0,1, with responses 3 cycles apart.
- req0 sel=4'b1111 -> err=1, result=0, zero=0, carry=0, and the next request is still served normally.
- `rsp_ready` held 0 for 10 cycles in RESP -> response fields unchanged, `req_ready`=0 throughout. With PERF_EN defined, `perf_stall` = 10.
- `rst` driven low during EXEC -> next cycle `rsp_valid=0`, state IDLE, `prio`=0. A pending req1 alone is then granted first.
